iter_divider: RTL and testbench

Parametrised multi-cycle radix-2 integer divider for the EXE stage. It replaces the vendor signed and unsigned divider cores with one unit that handles both signed and unsigned division. It has a valid/ready handshake on both sides and a pipeline-flush input for exception and ertn refill. It produces quotient and remainder together; the EXE stage selects div/mod results and stalls `es_ready_go` until `out_valid`.

---
 rtl/iter_divider.sv | 156 +++++++++++++++
 tb/tb_iter_divider.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider, signed or unsigned, one quotient bit per clock.
// Produces quotient and remainder together behind valid/ready handshakes, with a flush input.
module iter_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   dvd_q;
    logic [WIDTH-1:0]   dsr_q;
    logic [WIDTH-1:0]   rem_q;
    logic               q_neg_q;
    logic               r_neg_q;
    logic               out_valid_q;
    logic               busy_q;
    logic [WIDTH-1:0]   quotient_q;
    logic [WIDTH-1:0]   remainder_q;
    logic               dbz_q;

    logic [WIDTH:0]     shift_s;
    logic [WIDTH:0]     diff_s;
    logic               ge_s;
    logic [WIDTH-1:0]   rem_d;
    logic [WIDTH-1:0]   dvd_d;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // The most negative value maps onto itself, which is exactly its unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic is_signed);
        if (is_signed && x[WIDTH-1]) begin
            return negate(x);
        end else begin
            return x;
        end
    endfunction

    assign in_ready    = (state_q == IDLE) && !flush;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

    // One restoring step; a borrow out of the WIDTH+1 bit subtraction means shift < divisor.
    always_comb begin
        shift_s = {rem_q, dvd_q[WIDTH-1]};
        diff_s  = shift_s - {1'b0, dsr_q};
        ge_s    = !diff_s[WIDTH];
        if (ge_s) begin
            rem_d = diff_s[WIDTH-1:0];
        end else begin
            rem_d = shift_s[WIDTH-1:0];
        end
        dvd_d = {dvd_q[WIDTH-2:0], ge_s};
    end

    // Control FSM and datapath registers, with flush overriding every state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            dvd_q       <= {WIDTH{1'b0}};
            dsr_q       <= {WIDTH{1'b0}};
            rem_q       <= {WIDTH{1'b0}};
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            quotient_q  <= {WIDTH{1'b0}};
            remainder_q <= {WIDTH{1'b0}};
            dbz_q       <= 1'b0;
        end else if (flush) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        busy_q <= 1'b1;
                        if (divisor == {WIDTH{1'b0}}) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            quotient_q  <= {WIDTH{1'b1}};
                            remainder_q <= dividend;
                            dbz_q       <= 1'b1;
                        end else begin
                            state_q <= CALC;
                            dvd_q   <= magnitude(dividend, in_signed);
                            dsr_q   <= magnitude(divisor, in_signed);
                            q_neg_q <= in_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                            r_neg_q <= in_signed && dividend[WIDTH-1];
                            cnt_q   <= CNT_W'(WIDTH);
                            rem_q   <= {WIDTH{1'b0}};
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    dvd_q <= dvd_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        quotient_q  <= q_neg_q ? negate(dvd_d) : dvd_d;
                        remainder_q <= r_neg_q ? negate(rem_d) : rem_d;
                        dbz_q       <= 1'b0;
                    end else begin
                        state_q <= CALC;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end else begin
                        state_q <= DONE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider: a 32-bit and an 8-bit instance driven from one sequence.
module tb_iter_divider;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        a_in_valid, a_in_ready, a_in_signed, a_flush;
    logic [31:0] a_dividend, a_divisor, a_quotient, a_remainder;
    logic        a_out_valid, a_out_ready, a_dbz, a_busy;

    logic        b_in_valid, b_in_ready, b_in_signed, b_flush;
    logic [7:0]  b_dividend, b_divisor, b_quotient, b_remainder;
    logic        b_out_valid, b_out_ready, b_dbz, b_busy;

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    iter_divider #(.WIDTH(32)) dut32 (
        .clk(clk), .resetn(resetn), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_signed(a_in_signed), .dividend(a_dividend), .divisor(a_divisor), .flush(a_flush),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .quotient(a_quotient),
        .remainder(a_remainder), .div_by_zero(a_dbz), .busy(a_busy)
    );

    iter_divider #(.WIDTH(8)) dut8 (
        .clk(clk), .resetn(resetn), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_signed(b_in_signed), .dividend(b_dividend), .divisor(b_divisor), .flush(b_flush),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .quotient(b_quotient),
        .remainder(b_remainder), .div_by_zero(b_dbz), .busy(b_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue32(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b);
        a_in_valid  = 1'b1;
        a_in_signed = s;
        a_dividend  = a;
        a_divisor   = b;
        check({tag, ".in_ready"}, {31'd0, a_in_ready}, 32'd1);
        step();
        a_in_valid = 1'b0;
        a_dividend = 32'hDEAD_BEEF;
        a_divisor  = 32'h0000_0000;
    endtask

    task automatic run32(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic edz,
                         input int elat, input logic consume);
        int lat;
        issue32(tag, s, a, b);
        lat = 0;
        while (a_out_valid !== 1'b1 && lat < 100) begin
            step();
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(elat));
        check({tag, ".quotient"}, a_quotient, eq);
        check({tag, ".remainder"}, a_remainder, er);
        check({tag, ".dbz"}, {31'd0, a_dbz}, {31'd0, edz});
        check({tag, ".in_ready_busy"}, {31'd0, a_in_ready}, 32'd0);
        if (consume) begin
            a_out_ready = 1'b1;
            step();
            a_out_ready = 1'b0;
            check({tag, ".valid_drop"}, {31'd0, a_out_valid}, 32'd0);
            check({tag, ".ready_back"}, {31'd0, a_in_ready}, 32'd1);
        end
    endtask

    task automatic run8(input string tag, input logic s, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er, input int elat);
        int lat;
        b_in_valid  = 1'b1;
        b_in_signed = s;
        b_dividend  = a;
        b_divisor   = b;
        step();
        b_in_valid = 1'b0;
        b_dividend = 8'hA5;
        lat = 0;
        while (b_out_valid !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(elat));
        check({tag, ".quotient"}, {24'd0, b_quotient}, {24'd0, eq});
        check({tag, ".remainder"}, {24'd0, b_remainder}, {24'd0, er});
        b_out_ready = 1'b1;
        step();
        b_out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] x, y, eq8, er8;
        logic       sg;
        int         sx, sy, mq, mr, seen;

        resetn = 1'b0;
        a_in_valid = 1'b0; a_in_signed = 1'b0; a_flush = 1'b0; a_out_ready = 1'b0;
        a_dividend = 32'd0; a_divisor = 32'd0;
        b_in_valid = 1'b0; b_in_signed = 1'b0; b_flush = 1'b0; b_out_ready = 1'b0;
        b_dividend = 8'd0; b_divisor = 8'd0;
        #12;
        check("rst.out_valid", {31'd0, a_out_valid}, 32'd0);
        check("rst.busy", {31'd0, a_busy}, 32'd0);
        check("rst.quotient", a_quotient, 32'd0);
        check("rst.remainder", a_remainder, 32'd0);
        check("rst.dbz", {31'd0, a_dbz}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        step();
        check("rst.in_ready", {31'd0, a_in_ready}, 32'd1);

        run32("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 32, 1'b1);
        run32("u_ff_10", 1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 1'b0, 32, 1'b1);
        run32("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 32, 1'b1);
        run32("s_100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0, 32, 1'b1);
        run32("dbz", 1'b0, 32'd100, 32'd0, 32'hFFFF_FFFF, 32'd100, 1'b1, 0, 1'b1);

        // Flush ten cycles into CALC: nothing completes and stale outputs remain.
        issue32("flush", 1'b0, 32'd100, 32'd7);
        repeat (10) step();
        check("flush.busy", {31'd0, a_busy}, 32'd1);
        a_flush = 1'b1;
        #1;
        check("flush.in_ready_low", {31'd0, a_in_ready}, 32'd0);
        step();
        a_flush = 1'b0;
        #1;
        check("flush.in_ready", {31'd0, a_in_ready}, 32'd1);
        check("flush.busy_clr", {31'd0, a_busy}, 32'd0);
        check("flush.stale_q", a_quotient, 32'hFFFF_FFFF);
        check("flush.stale_dbz", {31'd0, a_dbz}, 32'd1);
        seen = 0;
        repeat (40) begin
            step();
            if (a_out_valid !== 1'b0) seen++;
        end
        check("flush.no_valid", 32'(seen), 32'd0);

        // Result held with out_ready low, then consumed.
        run32("hold_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 32, 1'b0);
        seen = 0;
        repeat (5) begin
            step();
            if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || a_quotient !== 32'd3
                || a_remainder !== 32'd0 || a_dbz !== 1'b0) seen++;
        end
        check("hold.stable", 32'(seen), 32'd0);
        a_out_ready = 1'b1;
        step();
        a_out_ready = 1'b0;
        check("hold.released", {31'd0, a_in_ready}, 32'd1);
        check("hold.valid_drop", {31'd0, a_out_valid}, 32'd0);

        // Flush while DONE discards the result.
        run32("dflush", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 32, 1'b0);
        a_flush = 1'b1;
        #1;
        check("dflush.in_ready_low", {31'd0, a_in_ready}, 32'd0);
        step();
        a_flush = 1'b0;
        #1;
        check("dflush.valid", {31'd0, a_out_valid}, 32'd0);
        check("dflush.in_ready", {31'd0, a_in_ready}, 32'd1);
        check("dflush.stale_q", a_quotient, 32'd10);

        run8("w8_m128_3", 1'b1, 8'h80, 8'd3, 8'hD6, 8'hFE, 8);
        run8("w8_ovf", 1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 8);
        run8("w8_u_255_7", 1'b0, 8'hFF, 8'd7, 8'd36, 8'd3, 8);
        for (int i = 0; i < 12; i++) begin
            x  = 8'($urandom);
            y  = 8'($urandom);
            sg = 1'($urandom_range(0, 1));
            if (y == 8'd0) y = 8'd1;
            if (sg) begin
                sx = $signed(x);
                sy = $signed(y);
            end else begin
                sx = {24'd0, x};
                sy = {24'd0, y};
            end
            mq  = sx / sy;
            mr  = sx % sy;
            eq8 = mq[7:0];
            er8 = mr[7:0];
            run8($sformatf("w8_rnd%0d", i), sg, x, y, eq8, er8, 8);
        end

        // Asynchronous reset in the middle of CALC.
        issue32("midrst", 1'b1, 32'd1000, 32'd7);
        repeat (5) step();
        resetn = 1'b0;
        #1;
        check("midrst.busy", {31'd0, a_busy}, 32'd0);
        check("midrst.valid", {31'd0, a_out_valid}, 32'd0);
        check("midrst.quotient", a_quotient, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        step();
        run32("post_rst", 1'b0, 32'd20, 32'd6, 32'd3, 32'd2, 1'b0, 32, 1'b1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
